// File: rtl/ddr3_dq_pad_seq_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_dq_pad_seq_pkg
// Shared DDR3 DQ-path definitions: default geometry/timing constants, the
// pad sequencer state encoding, and a counter-width helper.
// ---------------------------------------------------------------------------
package ddr3_dq_pad_seq_pkg;

   localparam int unsigned DDR3_DQ_W       = 16;
   localparam int unsigned DDR3_BL         = 8;
   localparam int unsigned DDR3_RD_LAT     = 5;
   localparam int unsigned DDR3_TURN_CYC   = 2;
   localparam int unsigned DDR3_FIFO_DEPTH = 2;

   typedef enum logic [2:0] {
      IDLE,
      WR_PRE,
      WR_BURST,
      WR_POST,
      RD_WAIT,
      RD_CAP
   } dq_state_e;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ddr3_rd_burst_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_rd_burst_fifo
// Small circular buffer holding complete captured read bursts.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full unless popping too)
//   push_data   : one full read burst
//   pop         : drop the head entry (ignored when empty)
//   head_data   : oldest entry, zero when empty
//   count       : number of stored entries
// ---------------------------------------------------------------------------
module ddr3_rd_burst_fifo
   import ddr3_dq_pad_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DDR3_DQ_W * DDR3_BL,
   parameter int unsigned DEPTH = DDR3_FIFO_DEPTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic [WIDTH-1:0]                 push_data,
   input  logic                             pop,
   output logic [WIDTH-1:0]                 head_data,
   output logic [cnt_width(DEPTH)-1:0]      count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      do_pop   = pop && (count_q != '0);
      // A full buffer still accepts a push when the head leaves in the same cycle.
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/ddr3_dq_pad_seq.sv
// ---------------------------------------------------------------------------
// ddr3_dq_pad_seq
// DDR3 DQ/DM/DQS pad sequencer: drives write bursts onto the pads with a
// strobe preamble/postamble, captures read bursts after a fixed latency and
// buffers them for the consumer, enforcing a bus turnaround gap.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_rw : burst request handshake (rw 0 write, 1 read)
//   wr_data_all, wr_mask_all   : write burst data/mask, beat 0 in LSBs
//   pad_dq_*, pad_dm_out       : data/mask pad controls
//   pad_dqs_out/_n_out/_oe     : strobe pad controls
//   pad_rw                     : 1 = pads receiving, 0 = pads driven
//   rd_data_all/rd_valid/rd_ready : buffered read burst output
//   busy                       : sequencer not idle
// ---------------------------------------------------------------------------
module ddr3_dq_pad_seq
   import ddr3_dq_pad_seq_pkg::*;
#(
   parameter int unsigned DQ_W       = DDR3_DQ_W,
   parameter int unsigned DM_W       = DQ_W / 8,
   parameter int unsigned DQS_W      = DQ_W / 8,
   parameter int unsigned BL         = DDR3_BL,
   parameter int unsigned RD_LAT     = DDR3_RD_LAT,
   parameter int unsigned TURN_CYC   = DDR3_TURN_CYC,
   parameter int unsigned FIFO_DEPTH = DDR3_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_rw,
   input  logic [DQ_W*BL-1:0]   wr_data_all,
   input  logic [DM_W*BL-1:0]   wr_mask_all,
   output logic [DQ_W-1:0]      pad_dq_out,
   output logic                 pad_dq_oe,
   input  logic [DQ_W-1:0]      pad_dq_in,
   output logic [DM_W-1:0]      pad_dm_out,
   output logic [DQS_W-1:0]     pad_dqs_out,
   output logic [DQS_W-1:0]     pad_dqs_n_out,
   output logic                 pad_dqs_oe,
   output logic                 pad_rw,
   output logic [DQ_W*BL-1:0]   rd_data_all,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic                 busy
);

   localparam int unsigned CNT_MAX = (BL > RD_LAT) ? BL : RD_LAT;
   localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
   localparam int unsigned TURN_W  = cnt_width(TURN_CYC);
   localparam int unsigned FCNT_W  = cnt_width(FIFO_DEPTH);

   dq_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TURN_W-1:0]     turn_cnt_q, turn_cnt_d;
   logic                  last_dir_q, last_dir_d;
   logic                  inflight_q, inflight_d;
   logic                  push_q, push_d;
   logic [DQ_W*BL-1:0]    wr_data_q, wr_data_d;
   logic [DM_W*BL-1:0]    wr_mask_q, wr_mask_d;
   logic [DQ_W*BL-1:0]    rd_buf_q, rd_buf_d;
   logic [FCNT_W-1:0]     fifo_count;
   logic                  rw_ok;
   logic                  room_ok;
   logic                  accept;

   // Ready depends only on registered state and the requested direction.
   always_comb begin
      rw_ok     = (cmd_rw == last_dir_q) || (turn_cnt_q == '0);
      room_ok   = !cmd_rw || ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
      cmd_ready = (state_q == IDLE) && rw_ok && room_ok;
      accept    = cmd_valid && cmd_ready;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      turn_cnt_d = turn_cnt_q;
      last_dir_d = last_dir_q;
      inflight_d = inflight_q;
      push_d     = 1'b0;
      wr_data_d  = wr_data_q;
      wr_mask_d  = wr_mask_q;
      rd_buf_d   = rd_buf_q;

      // The pushed burst is now counted by the FIFO; a read accepted in the
      // same cycle re-arms the flag below.
      if (push_q) begin
         inflight_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (turn_cnt_q != '0) begin
               turn_cnt_d = turn_cnt_q - 1'b1;
            end
            if (accept) begin
               last_dir_d = cmd_rw;
               cnt_d      = '0;
               if (cmd_rw) begin
                  inflight_d = 1'b1;
                  state_d    = (RD_LAT == 1) ? RD_CAP : RD_WAIT;
               end else begin
                  wr_data_d = wr_data_all;
                  wr_mask_d = wr_mask_all;
                  state_d   = WR_PRE;
               end
            end
         end
         WR_PRE: begin
            cnt_d   = '0;
            state_d = WR_BURST;
         end
         WR_BURST: begin
            if (cnt_q == CNT_W'(BL - 1)) begin
               state_d = WR_POST;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_POST: begin
            turn_cnt_d = TURN_W'(TURN_CYC);
            state_d    = IDLE;
         end
         RD_WAIT: begin
            if (cnt_q == CNT_W'(RD_LAT - 2)) begin
               cnt_d   = '0;
               state_d = RD_CAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RD_CAP: begin
            for (int unsigned i = 0; i < BL; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  rd_buf_d[i*DQ_W +: DQ_W] = pad_dq_in;
               end
            end
            if (cnt_q == CNT_W'(BL - 1)) begin
               push_d     = 1'b1;
               turn_cnt_d = TURN_W'(TURN_CYC);
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         turn_cnt_q <= '0;
         last_dir_q <= 1'b1;
         inflight_q <= 1'b0;
         push_q     <= 1'b0;
         wr_data_q  <= '0;
         wr_mask_q  <= '0;
         rd_buf_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         turn_cnt_q <= turn_cnt_d;
         last_dir_q <= last_dir_d;
         inflight_q <= inflight_d;
         push_q     <= push_d;
         wr_data_q  <= wr_data_d;
         wr_mask_q  <= wr_mask_d;
         rd_buf_q   <= rd_buf_d;
      end
   end

   // Pad outputs decode straight from state so an asynchronous reset
   // releases the bus in the same cycle.
   always_comb begin
      pad_dq_oe   = (state_q == WR_PRE) || (state_q == WR_BURST) || (state_q == WR_POST);
      pad_dqs_oe  = pad_dq_oe;
      pad_rw      = ~pad_dq_oe;
      pad_dq_out  = '0;
      pad_dm_out  = '0;
      pad_dqs_out = '0;
      if (state_q == WR_BURST) begin
         for (int unsigned i = 0; i < BL; i++) begin
            if (cnt_q == CNT_W'(i)) begin
               pad_dq_out = wr_data_q[i*DQ_W +: DQ_W];
               pad_dm_out = wr_mask_q[i*DM_W +: DM_W];
            end
         end
         pad_dqs_out = cnt_q[0] ? '0 : '1;
      end
      pad_dqs_n_out = pad_dqs_oe ? ~pad_dqs_out : '1;
      busy          = (state_q != IDLE);
   end

   ddr3_rd_burst_fifo #(
      .WIDTH (DQ_W * BL),
      .DEPTH (FIFO_DEPTH)
   ) u_rd_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_q),
      .push_data (rd_buf_q),
      .pop       (rd_valid && rd_ready),
      .head_data (rd_data_all),
      .count     (fifo_count)
   );

   assign rd_valid = (fifo_count != '0);

endmodule

// File: tb/tb_ddr3_dq_pad_seq.sv
// ---------------------------------------------------------------------------
// tb_ddr3_dq_pad_seq
// Directed bench for ddr3_dq_pad_seq with default geometry (16 DQ, BL8,
// read latency 5, turnaround 2, two-burst read buffer). A DRAM-side driver
// returns base+beat on pad_dq_in for every accepted read.
// ---------------------------------------------------------------------------
module tb_ddr3_dq_pad_seq;

   localparam int DQ_W       = 16;
   localparam int DM_W       = 2;
   localparam int DQS_W      = 2;
   localparam int BL         = 8;
   localparam int RD_LAT     = 5;
   localparam int TURN_CYC   = 2;
   localparam int FIFO_DEPTH = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic                 cmd_rw = 1'b1;
   logic [DQ_W*BL-1:0]   wr_data_all = '0;
   logic [DM_W*BL-1:0]   wr_mask_all = '0;
   logic [DQ_W-1:0]      pad_dq_out;
   logic                 pad_dq_oe;
   logic [DQ_W-1:0]      pad_dq_in = '0;
   logic [DM_W-1:0]      pad_dm_out;
   logic [DQS_W-1:0]     pad_dqs_out;
   logic [DQS_W-1:0]     pad_dqs_n_out;
   logic                 pad_dqs_oe;
   logic                 pad_rw;
   logic [DQ_W*BL-1:0]   rd_data_all;
   logic                 rd_valid;
   logic                 rd_ready = 1'b0;
   logic                 busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      int          acc;
      logic [15:0] base;
   } rd_req_t;
   rd_req_t rdq[$];
   logic [15:0] drv_val;

   ddr3_dq_pad_seq #(
      .DQ_W       (DQ_W),
      .DM_W       (DM_W),
      .DQS_W      (DQS_W),
      .BL         (BL),
      .RD_LAT     (RD_LAT),
      .TURN_CYC   (TURN_CYC),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_rw        (cmd_rw),
      .wr_data_all   (wr_data_all),
      .wr_mask_all   (wr_mask_all),
      .pad_dq_out    (pad_dq_out),
      .pad_dq_oe     (pad_dq_oe),
      .pad_dq_in     (pad_dq_in),
      .pad_dm_out    (pad_dm_out),
      .pad_dqs_out   (pad_dqs_out),
      .pad_dqs_n_out (pad_dqs_n_out),
      .pad_dqs_oe    (pad_dqs_oe),
      .pad_rw        (pad_rw),
      .rd_data_all   (rd_data_all),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // DRAM model: beat i of a read accepted in cycle A is on the pins during A+RD_LAT+i.
   always @(negedge clk) begin
      drv_val = 16'hDEAD;
      foreach (rdq[j]) begin
         if (cyc >= rdq[j].acc + RD_LAT && cyc < rdq[j].acc + RD_LAT + BL)
            drv_val = rdq[j].base + 16'(cyc - rdq[j].acc - RD_LAT);
      end
      pad_dq_in = drv_val;
   end

   function automatic logic [DQ_W*BL-1:0] burst_of(input logic [15:0] base);
      logic [DQ_W*BL-1:0] v;
      for (int i = 0; i < BL; i++) v[i*DQ_W +: DQ_W] = base + 16'(i);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a command and holds it until accepted; returns in the cycle after accept.
   task automatic issue(input logic rw, input logic [DQ_W*BL-1:0] d, input logic [DM_W*BL-1:0] m,
                        input logic [15:0] base, output int acc);
      rd_req_t r;
      cmd_rw      = rw;
      wr_data_all = d;
      wr_mask_all = m;
      cmd_valid   = 1'b1;
      acc         = -1;
      for (int n = 0; n < 200; n++) begin
         #1;
         if (cmd_ready === 1'b1) begin
            acc = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (acc < 0) begin
         failures++;
         $display("FAIL issue_timeout: rw=%0b got no cmd_ready within 200 cycles", rw);
      end else if (rw) begin
         r.acc  = acc;
         r.base = base;
         rdq.push_back(r);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      cmd_rw = 1'b1;
      #1;
      checks++;
      if ({pad_dq_oe, pad_dqs_oe, pad_rw, busy, rd_valid} !== 5'b00100) begin
         failures++;
         $display("FAIL reset_ctrl: got %b exp 00100", {pad_dq_oe, pad_dqs_oe, pad_rw, busy, rd_valid});
      end
      checks++;
      if ({pad_dq_out, pad_dm_out, pad_dqs_out, pad_dqs_n_out} !== {16'h0000, 2'b00, 2'b00, 2'b11}) begin
         failures++;
         $display("FAIL reset_pads: got %h exp %h", {pad_dq_out, pad_dm_out, pad_dqs_out, pad_dqs_n_out},
                  {16'h0000, 2'b00, 2'b00, 2'b11});
      end
      checks++;
      if (rd_data_all !== '0) begin
         failures++;
         $display("FAIL reset_rd_data: got %h exp 0", rd_data_all);
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready);
      end
   endtask

   task automatic test_write();
      logic [DQ_W*BL-1:0] d;
      logic [15:0]        e_dq;
      logic [1:0]         e_dqs;
      logic               e_oe;
      int                 t;
      d = burst_of(16'h1000);
      issue(1'b0, d, '0, 16'h0, t);
      for (int k = 1; k <= 11; k++) begin
         e_oe  = (k <= 10);
         e_dq  = (k >= 2 && k <= 9) ? 16'h1000 + 16'(k - 2) : 16'h0000;
         e_dqs = (k >= 2 && k <= 9 && ((k - 2) % 2 == 0)) ? 2'b11 : 2'b00;
         checks++;
         if ({pad_dq_oe, pad_dqs_oe, pad_rw, busy} !== {e_oe, e_oe, ~e_oe, e_oe}) begin
            failures++;
            $display("FAIL wr_ctrl T+%0d: got %b exp %b", k, {pad_dq_oe, pad_dqs_oe, pad_rw, busy},
                     {e_oe, e_oe, ~e_oe, e_oe});
         end
         checks++;
         if ({pad_dq_out, pad_dm_out} !== {e_dq, 2'b00}) begin
            failures++;
            $display("FAIL wr_dq T+%0d: got %h exp %h", k, {pad_dq_out, pad_dm_out}, {e_dq, 2'b00});
         end
         checks++;
         if ({pad_dqs_out, pad_dqs_n_out} !== {e_dqs, (e_oe ? ~e_dqs : 2'b11)}) begin
            failures++;
            $display("FAIL wr_dqs T+%0d: got %b exp %b", k, {pad_dqs_out, pad_dqs_n_out},
                     {e_dqs, (e_oe ? ~e_dqs : 2'b11)});
         end
         if (k == 11) begin
            cmd_rw = 1'b1;
            #1;
            checks++;
            if (cmd_ready !== 1'b0) begin
               failures++;
               $display("FAIL wr_turn_read_ready: got %b exp 0", cmd_ready);
            end
            cmd_rw = 1'b0;
            #1;
            checks++;
            if (cmd_ready !== 1'b1) begin
               failures++;
               $display("FAIL wr_same_dir_ready: got %b exp 1", cmd_ready);
            end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      int tb_, tc;
      logic [1:0] e_dm;
      issue(1'b0, burst_of(16'h1100), '0, 16'h0, tb_);
      issue(1'b0, burst_of(16'h5A00), 16'hE4E4, 16'h0, tc);
      checks++;
      if (tc !== tb_ + BL + 3) begin
         failures++;
         $display("FAIL b2b_accept: got T+%0d exp T+%0d", tc - tb_, BL + 3);
      end
      step();
      for (int i = 0; i < BL; i++) begin
         e_dm = 2'(i % 4);
         checks++;
         if ({pad_dq_out, pad_dm_out} !== {16'h5A00 + 16'(i), e_dm}) begin
            failures++;
            $display("FAIL b2b_beat%0d: got %h exp %h", i, {pad_dq_out, pad_dm_out}, {16'h5A00 + 16'(i), e_dm});
         end
         step();
      end
      checks++;
      if ({pad_dq_oe, pad_dqs_out, pad_dqs_n_out, pad_dq_out} !== {1'b1, 2'b00, 2'b11, 16'h0}) begin
         failures++;
         $display("FAIL b2b_post: got %h exp %h", {pad_dq_oe, pad_dqs_out, pad_dqs_n_out, pad_dq_out},
                  {1'b1, 2'b00, 2'b11, 16'h0});
      end
      step();
      checks++;
      if ({busy, pad_dq_oe} !== 2'b00) begin
         failures++;
         $display("FAIL b2b_idle: got %b exp 00", {busy, pad_dq_oe});
      end
   endtask

   task automatic test_read();
      int t, got;
      logic oe_bad;
      oe_bad = 1'b0;
      issue(1'b1, '0, '0, 16'hA000, t);
      got = -1;
      for (int n = 0; n < 40; n++) begin
         if (rd_valid === 1'b1) begin
            got = cyc;
            break;
         end
         if (pad_dq_oe !== 1'b0 || pad_rw !== 1'b1) oe_bad = 1'b1;
         step();
      end
      checks++;
      if (got !== t + RD_LAT + BL + 1) begin
         failures++;
         $display("FAIL rd_latency: got T+%0d exp T+%0d", got - t, RD_LAT + BL + 1);
      end
      checks++;
      if (rd_data_all !== burst_of(16'hA000)) begin
         failures++;
         $display("FAIL rd_data: got %h exp %h", rd_data_all, burst_of(16'hA000));
      end
      checks++;
      if (oe_bad !== 1'b0) begin
         failures++;
         $display("FAIL rd_pads_driven: got %b exp 0", oe_bad);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL rd_pop: got %b exp 0", rd_valid);
      end
   endtask

   task automatic test_turnaround();
      int tw, tr, got;
      logic overlap;
      overlap = 1'b0;
      issue(1'b0, burst_of(16'h2000), '0, 16'h0, tw);
      issue(1'b1, '0, '0, 16'h3000, tr);
      checks++;
      if (tr !== tw + BL + 3 + TURN_CYC) begin
         failures++;
         $display("FAIL turn_accept: got T+%0d exp T+%0d", tr - tw, BL + 3 + TURN_CYC);
      end
      got = -1;
      for (int n = 0; n < 40; n++) begin
         if (rd_valid === 1'b1) begin
            got = cyc;
            break;
         end
         if (pad_dq_oe !== 1'b0) overlap = 1'b1;
         step();
      end
      checks++;
      if (overlap !== 1'b0 || got < 0) begin
         failures++;
         $display("FAIL turn_overlap: got overlap=%b valid_cyc=%0d exp overlap=0", overlap, got);
      end
      checks++;
      if (rd_data_all !== burst_of(16'h3000)) begin
         failures++;
         $display("FAIL turn_rd_data: got %h exp %h", rd_data_all, burst_of(16'h3000));
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
   endtask

   task automatic test_fifo_full();
      int a1, a2, a3, pc;
      logic seen_ready;
      rd_ready = 1'b0;
      issue(1'b1, '0, '0, 16'hB000, a1);
      issue(1'b1, '0, '0, 16'hC000, a2);
      checks++;
      if (a2 !== a1 + RD_LAT + BL) begin
         failures++;
         $display("FAIL full_second_accept: got T+%0d exp T+%0d", a2 - a1, RD_LAT + BL);
      end
      cmd_rw     = 1'b1;
      cmd_valid  = 1'b1;
      seen_ready = 1'b0;
      for (int n = 0; n < 25; n++) begin
         #1;
         if (cmd_ready !== 1'b0) seen_ready = 1'b1;
         step();
      end
      checks++;
      if (seen_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_stall: got ready=%b exp 0", seen_ready);
      end
      checks++;
      if ({rd_valid, rd_data_all} !== {1'b1, burst_of(16'hB000)}) begin
         failures++;
         $display("FAIL full_head_first: got %h exp %h", {rd_valid, rd_data_all}, {1'b1, burst_of(16'hB000)});
      end
      pc = cyc;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      issue(1'b1, '0, '0, 16'hD000, a3);
      checks++;
      if (a3 !== pc + 1) begin
         failures++;
         $display("FAIL full_release: got pop+%0d exp pop+1", a3 - pc);
      end
      checks++;
      if (rd_data_all !== burst_of(16'hC000)) begin
         failures++;
         $display("FAIL full_head_second: got %h exp %h", rd_data_all, burst_of(16'hC000));
      end
      for (int n = 0; n < 40 && cyc < a3 + RD_LAT + BL; n++) step();
      rd_ready = 1'b1;
      #1;
      checks++;
      if ({rd_valid, rd_data_all} !== {1'b1, burst_of(16'hC000)}) begin
         failures++;
         $display("FAIL pushpop_head_before: got %h exp %h", {rd_valid, rd_data_all}, {1'b1, burst_of(16'hC000)});
      end
      step();
      rd_ready = 1'b0;
      checks++;
      if ({rd_valid, rd_data_all} !== {1'b1, burst_of(16'hD000)}) begin
         failures++;
         $display("FAIL pushpop_head_after: got %h exp %h", {rd_valid, rd_data_all}, {1'b1, burst_of(16'hD000)});
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL pushpop_drain: got %b exp 0", rd_valid);
      end
   endtask

   task automatic test_reset_mid_burst();
      int tr, tw, ta;
      logic spurious;
      issue(1'b1, '0, '0, 16'hE000, tr);
      for (int n = 0; n < 40 && rd_valid !== 1'b1; n++) step();
      issue(1'b0, burst_of(16'h4000), '0, 16'h0, tw);
      for (int n = 0; n < 10 && cyc < tw + 5; n++) step();
      checks++;
      if ({pad_dq_oe, pad_dq_out, pad_dqs_out, rd_valid} !== {1'b1, 16'h4003, 2'b00, 1'b1}) begin
         failures++;
         $display("FAIL rst_pre_beat3: got %h exp %h", {pad_dq_oe, pad_dq_out, pad_dqs_out, rd_valid},
                  {1'b1, 16'h4003, 2'b00, 1'b1});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pad_dq_oe, pad_dqs_oe, pad_rw, busy, rd_valid} !== 5'b00100) begin
         failures++;
         $display("FAIL rst_mid_ctrl: got %b exp 00100", {pad_dq_oe, pad_dqs_oe, pad_rw, busy, rd_valid});
      end
      checks++;
      if ({pad_dq_out, pad_dm_out, pad_dqs_out, pad_dqs_n_out} !== {16'h0000, 2'b00, 2'b00, 2'b11}) begin
         failures++;
         $display("FAIL rst_mid_pads: got %h exp %h", {pad_dq_out, pad_dm_out, pad_dqs_out, pad_dqs_n_out},
                  {16'h0000, 2'b00, 2'b00, 2'b11});
      end
      checks++;
      if (rd_data_all !== '0) begin
         failures++;
         $display("FAIL rst_mid_rd_data: got %h exp 0", rd_data_all);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      cmd_rw = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_ready_after: got %b exp 1", cmd_ready);
      end
      // Reset during read capture must not leave a burst behind.
      issue(1'b1, '0, '0, 16'hF000, ta);
      for (int n = 0; n < 10 && cyc < ta + RD_LAT + 2; n++) step();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 1'b0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (rd_valid !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_push: got rd_valid seen=%b exp 0", spurious);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_read();
      test_turnaround();
      test_fifo_full();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
